// File: rtl/rptr_empty_fwft_if.sv
`default_nettype none
// ============================================================================
// rptr_empty_fwft_if : read-side FIFO bus (sync pointers, memory port, stream)
// Revision: 1.0
// ============================================================================
interface rptr_empty_fwft_if #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_SIZE = 8
);
  logic [ADDR_SIZE:0]   wptr;
  logic [ADDR_SIZE:0]   rptr;
  logic [ADDR_SIZE-1:0] raddr;
  logic                 ren;
  logic [DATA_SIZE-1:0] rdata_mem;
  logic                 rempty;
  logic [ADDR_SIZE:0]   rlevel;
  logic                 ralmost_empty;
  logic                 rvalid;
  logic                 rready;
  logic [DATA_SIZE-1:0] rdata;

  modport master (
    input  wptr, rdata_mem, rready,
    output rptr, raddr, ren, rempty, rlevel, ralmost_empty, rvalid, rdata
  );

  modport slave (
    output wptr, rdata_mem, rready,
    input  rptr, raddr, ren, rempty, rlevel, ralmost_empty, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/rptr_empty_fwft.sv
`default_nettype none
// ============================================================================
// rptr_empty_fwft : async-FIFO read pointer, empty/level flags, 2-entry FWFT stage
// Revision: 1.0
// ============================================================================
module rptr_empty_fwft #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_SIZE = 8,
  parameter int AE_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst,
  rptr_empty_fwft_if.master   bus
);
  localparam logic [ADDR_SIZE:0] AE_LIM = (ADDR_SIZE + 1)'(AE_THRESH);

  logic [ADDR_SIZE:0]   rq1_wptr;
  logic [ADDR_SIZE:0]   rq2_wptr;
  logic [ADDR_SIZE:0]   rq2_wbin;
  logic [ADDR_SIZE:0]   rbin;
  logic [ADDR_SIZE:0]   rbin_next;
  logic [ADDR_SIZE:0]   rgray_next;
  logic [ADDR_SIZE:0]   rptr;
  logic [ADDR_SIZE:0]   level_next;
  logic [ADDR_SIZE:0]   rlevel;
  logic                 rempty;
  logic                 ralmost_empty;
  logic                 ren;
  logic [1:0]           ocnt;
  logic [1:0]           credit;
  logic                 inflight;
  logic                 pop;
  logic                 head_free;
  logic [DATA_SIZE-1:0] head;
  logic [DATA_SIZE-1:0] tail;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rq2_wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rq2_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign pop        = (ocnt != 2'd0) & bus.rready;
  assign credit     = ocnt + {1'b0, inflight} - {1'b0, pop};
  assign head_free  = ((ocnt - {1'b0, pop}) == 2'd0);
  assign ren        = ~rempty & (credit < 2'd2);
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, ren};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign level_next = rq2_wbin - rbin;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr      <= '0;
      rq2_wptr      <= '0;
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      ocnt          <= 2'd0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
    end else begin
      rq1_wptr      <= bus.wptr;
      rq2_wptr      <= rq1_wptr;
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_LIM);
      inflight      <= ren;
      ocnt          <= credit;
      // A pop from a full stage and a capture into the head never coincide.
      if (inflight) begin
        if (head_free) head <= bus.rdata_mem;
        else           tail <= bus.rdata_mem;
      end
      if (pop && (ocnt == 2'd2)) head <= tail;
    end
  end

  assign bus.rptr          = rptr;
  assign bus.raddr         = rbin[ADDR_SIZE-1:0];
  assign bus.ren           = ren;
  assign bus.rempty        = rempty;
  assign bus.rlevel        = rlevel;
  assign bus.ralmost_empty = ralmost_empty;
  assign bus.rvalid        = (ocnt != 2'd0);
  assign bus.rdata         = head;
endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_fwft.sv
`default_nettype none
// ============================================================================
// tb_rptr_empty_fwft : self-checking bench with scoreboard, vector table, random run
// Revision: 1.0
// ============================================================================
module tb_rptr_empty_fwft;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rptr_empty_fwft_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus();

  rptr_empty_fwft #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AE_THRESH(1)) dut (
    .rclk (clk),
    .rrst (rst),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ren_cnt = 0;
  logic hold_prev = 1'b0;
  logic [DW-1:0] hold_data;

  // Synchronous-read memory: data appears the cycle after ren.
  always @(posedge clk) if (bus.ren) bus.rdata_mem <= mem[bus.raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard: every accepted word must be the oldest word made available.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.ren) begin
        ren_cnt++;
        check("ren_not_empty", {31'd0, bus.rempty}, 32'd0);
      end
      if (hold_prev) begin
        check("hold_valid", {31'd0, bus.rvalid}, 32'd1);
        check("hold_data", {24'd0, bus.rdata}, {24'd0, hold_data});
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_pop: got %0h expected no word", bus.rdata);
        end else begin
          check("pop_data", {24'd0, bus.rdata}, {24'd0, exp_q.pop_front()});
        end
      end
      hold_prev = bus.rvalid && !bus.rready;
      hold_data = bus.rdata;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [AW:0] wp);
    rst = 1'b1;
    bus.wptr = wp;
    bus.rready = 1'b0;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    bus.rready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      cyc(1);
      t++;
    end
    check(name, exp_q.size(), 0);
    cyc(3);
  endtask

  task automatic single_word();
    mem[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    bus.wptr = 4'b0001;
    cyc(4);
    check("sw_valid_e4", {31'd0, bus.rvalid}, 32'd0);
    cyc(1);
    check("sw_valid_e5", {31'd0, bus.rvalid}, 32'd1);
    check("sw_data", {24'd0, bus.rdata}, 32'hA5);
    bus.rready = 1'b1;
    cyc(1);
    bus.rready = 1'b0;
    check("sw_valid_after", {31'd0, bus.rvalid}, 32'd0);
    check("sw_empty_after", {31'd0, bus.rempty}, 32'd1);
    check("sw_rptr", {28'd0, bus.rptr}, 32'h1);
    check("sw_consumed", exp_q.size(), 0);
  endtask

  typedef struct {
    int         wcnt;
    int         exp_ren;
    logic [3:0] exp_level;
    logic       exp_ae;
    logic       exp_empty;
    logic [3:0] exp_rptr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, k, first, run;
    logic [AW:0] wcount;

    vecs[0] = '{0, 0, 4'd0, 1'b1, 1'b1, 4'b0000};
    vecs[1] = '{1, 1, 4'd0, 1'b1, 1'b1, 4'b0001};
    vecs[2] = '{2, 2, 4'd0, 1'b1, 1'b1, 4'b0011};
    vecs[3] = '{3, 2, 4'd1, 1'b1, 1'b0, 4'b0010};
    vecs[4] = '{5, 2, 4'd3, 1'b0, 1'b0, 4'b0111};
    vecs[5] = '{8, 2, 4'd6, 1'b0, 1'b0, 4'b1100};

    // Reset with a stale non-zero write pointer present.
    rst = 1'b1;
    bus.wptr = 4'b0110;
    bus.rready = 1'b0;
    cyc(1);
    check("rst_empty", {31'd0, bus.rempty}, 32'd1);
    check("rst_valid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_ren", {31'd0, bus.ren}, 32'd0);
    check("rst_rptr", {28'd0, bus.rptr}, 32'd0);
    check("rst_level", {28'd0, bus.rlevel}, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("post_rst_empty", {31'd0, bus.rempty}, 32'd1);
    check("post_rst_valid", {31'd0, bus.rvalid}, 32'd0);
    check("post_rst_ren", {31'd0, bus.ren}, 32'd0);
    check("post_rst_rptr", {28'd0, bus.rptr}, 32'd0);
    check("post_rst_level", {28'd0, bus.rlevel}, 32'd0);

    do_reset(4'b0000);
    single_word();

    // Full-rate drain across the address wrap.
    do_reset(4'b0000);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(i);
      exp_q.push_back(8'(i));
    end
    bus.rready = 1'b1;
    bus.wptr = 4'b1100;
    k = 0; first = -1; run = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ren) begin
        check("fr_raddr", {29'd0, bus.raddr}, k % 8);
        k++;
      end
      if (bus.rvalid) begin
        if (first < 0) first = c;
        if (c - first == run) run++;
      end
    end
    cyc(1);
    check("fr_consecutive", run, 8);
    check("fr_words", exp_q.size(), 0);
    check("fr_rptr", {28'd0, bus.rptr}, 32'hC);
    check("fr_empty", {31'd0, bus.rempty}, 32'd1);
    check("fr_raddr_wrap", {29'd0, bus.raddr}, 32'd0);

    // Level flag timing right after synchronization.
    do_reset(4'b0000);
    for (int i = 0; i < 3; i++) begin
      mem[i] = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
    end
    bus.wptr = gray(4'd3);
    cyc(2);
    check("lvl_lag", {28'd0, bus.rlevel}, 32'd0);
    cyc(1);
    check("lvl_sync", {28'd0, bus.rlevel}, 32'd3);
    check("ae_sync", {31'd0, bus.ralmost_empty}, 32'd0);
    drain("lvl_drain");

    // Backpressure / level vectors.
    foreach (vecs[v]) begin
      do_reset(4'b0000);
      for (int i = 0; i < vecs[v].wcnt; i++) begin
        mem[i % 8] = 8'h10 + 8'(i);
        exp_q.push_back(8'h10 + 8'(i));
      end
      r0 = ren_cnt;
      bus.wptr = gray(4'(vecs[v].wcnt));
      cyc(12);
      check("bp_ren_pulses", ren_cnt - r0, vecs[v].exp_ren);
      check("bp_level", {28'd0, bus.rlevel}, {28'd0, vecs[v].exp_level});
      check("bp_ae", {31'd0, bus.ralmost_empty}, {31'd0, vecs[v].exp_ae});
      check("bp_empty", {31'd0, bus.rempty}, {31'd0, vecs[v].exp_empty});
      check("bp_valid", {31'd0, bus.rvalid}, (vecs[v].wcnt > 0) ? 32'd1 : 32'd0);
      if (vecs[v].wcnt > 0) check("bp_head", {24'd0, bus.rdata}, 32'h10);
      drain("bp_drain");
      check("bp_rptr", {28'd0, bus.rptr}, {28'd0, vecs[v].exp_rptr});
      check("bp_end_empty", {31'd0, bus.rempty}, 32'd1);
      check("bp_raddr", {29'd0, bus.raddr}, vecs[v].wcnt % 8);
    end

    // Mid-burst reset while the stage is filling, then restart.
    do_reset(4'b0000);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h50 + 8'(i);
      exp_q.push_back(8'h50 + 8'(i));
    end
    bus.wptr = 4'b1100;
    cyc(5);
    check("mb_valid_pre", {31'd0, bus.rvalid}, 32'd1);
    rst = 1'b1;
    bus.wptr = 4'b0000;
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
    check("mb_valid", {31'd0, bus.rvalid}, 32'd0);
    check("mb_empty", {31'd0, bus.rempty}, 32'd1);
    check("mb_ren", {31'd0, bus.ren}, 32'd0);
    check("mb_rptr", {28'd0, bus.rptr}, 32'd0);
    check("mb_raddr", {29'd0, bus.raddr}, 32'd0);
    check("mb_level", {28'd0, bus.rlevel}, 32'd0);
    check("mb_ae", {31'd0, bus.ralmost_empty}, 32'd1);
    check("mb_rdata", {24'd0, bus.rdata}, 32'd0);
    single_word();

    // Randomized traffic against the scoreboard.
    do_reset(4'b0000);
    wcount = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 60 && exp_q.size() < 8) begin
        mem[wcount[AW-1:0]] = 8'($urandom);
        exp_q.push_back(mem[wcount[AW-1:0]]);
        wcount = wcount + 1'b1;
        bus.wptr = gray(wcount);
      end
      bus.rready = ($urandom_range(0, 99) < 65);
      cyc(1);
    end
    drain("rnd_drain");
    check("rnd_empty", {31'd0, bus.rempty}, 32'd1);
    check("rnd_valid", {31'd0, bus.rvalid}, 32'd0);
    check("rnd_rptr", {28'd0, bus.rptr}, {28'd0, gray(wcount)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
